// File: rtl/branch_pred_pkg.sv
// ============================================================================
// Module  : branch_pred_pkg
// Brief   : Shared types and counter helpers for the branch predictor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_pred_pkg;

  // Counters are stored at a fixed maximum width; CNT_WIDTH must not exceed it.
  localparam int unsigned CNT_MAX_W = 8;

  typedef logic [CNT_MAX_W-1:0] cnt_t;

  typedef enum logic {
    BR_BRANCH = 1'b0,
    BR_RET    = 1'b1
  } br_type_e;

  typedef struct packed {
    logic        valid;
    br_type_e    is_ret;
    logic [31:0] pc;
    logic [31:0] target;
    cnt_t        cnt;
  } btb_entry_t;

  // Weakly-taken start value: only the counter MSB set.
  function automatic cnt_t cnt_init(input int unsigned width);
    cnt_init = cnt_t'(1) << (width - 1);
  endfunction

  function automatic cnt_t cnt_limit(input int unsigned width);
    cnt_limit = (cnt_t'(1) << width) - cnt_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ret_addr_stack.sv
// ============================================================================
// Module  : ret_addr_stack
// Brief   : Circular return-address stack; overflow overwrites the oldest.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ret_addr_stack #(
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_flush,
  input  logic        i_push,
  input  logic [31:0] i_push_adr,
  input  logic        i_pop,
  output logic [31:0] o_top_adr,
  output logic        o_full,
  output logic        o_empty
);

  localparam int unsigned c_PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned c_CNT_W = c_PTR_W + 1;

  logic [31:0]        r_stack [RAS_DEPTH];
  logic [c_PTR_W-1:0] r_top;
  logic [c_CNT_W-1:0] r_count;

  logic               w_full;
  logic               w_empty;
  logic               w_do_push;
  logic               w_do_replace;
  logic               w_do_pop;
  logic [c_PTR_W-1:0] w_top_inc;

  assign w_full       = (r_count == c_CNT_W'(RAS_DEPTH));
  assign w_empty      = (r_count == '0);
  // Push+pop on an empty stack has nothing to replace, so it is a plain push.
  assign w_do_push    = i_push & (~i_pop | w_empty);
  assign w_do_replace = i_push & i_pop & ~w_empty;
  assign w_do_pop     = i_pop & ~i_push & ~w_empty;
  assign w_top_inc    = r_top + c_PTR_W'(1);

  always_ff @(posedge clk) begin
    if (!reset_n || i_flush) begin
      r_top   <= '0;
      r_count <= '0;
    end else if (w_do_push) begin
      r_top <= w_top_inc;
      if (!w_full) begin
        r_count <= r_count + c_CNT_W'(1);
      end
    end else if (w_do_pop) begin
      r_top   <= r_top - c_PTR_W'(1);
      r_count <= r_count - c_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && !i_flush && (w_do_push || w_do_replace)) begin
      r_stack[w_do_push ? w_top_inc : r_top] <= i_push_adr;
    end
  end

  assign o_top_adr = r_stack[r_top];
  assign o_full    = w_full;
  assign o_empty   = w_empty;

endmodule

`default_nettype wire

// File: rtl/branch_pred.sv
// ============================================================================
// Module  : branch_pred
// Brief   : Fully-associative BTB with saturating counters plus a RAS.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_pred
  import branch_pred_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = 4,
  parameter int unsigned RAS_DEPTH   = 8,
  parameter int unsigned CNT_WIDTH   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        LOOKUP_VALID_SI,
  input  logic [31:0] LOOKUP_ADR_SI,
  output logic        PRED_TAKEN_SI,
  output logic [31:0] PRED_ADR_SI,
  output logic        BTB_HIT_SI,
  input  logic        UPD_VALID_RD,
  input  logic [31:0] UPD_ADR_RD,
  input  logic [31:0] UPD_TARGET_RD,
  input  logic        UPD_TAKEN_RD,
  input  logic        UPD_IS_RET_RD,
  input  logic        RAS_PUSH_RD,
  input  logic [31:0] RAS_PUSH_ADR_RD,
  input  logic        RAS_POP_RD,
  input  logic        FLUSH_ALL_SD,
  output logic        RAS_FULL_SI,
  output logic        RAS_EMPTY_SI
);

  localparam int unsigned c_IDX_W    = $clog2(BTB_ENTRIES);
  localparam cnt_t        c_CNT_INIT = cnt_init(CNT_WIDTH);
  localparam cnt_t        c_CNT_MAX  = cnt_limit(CNT_WIDTH);

  btb_entry_t         r_btb [BTB_ENTRIES];
  logic [c_IDX_W-1:0] r_rr_ptr;

  logic               w_lk_hit;
  logic [c_IDX_W-1:0] w_lk_idx;
  logic               w_upd_hit;
  logic [c_IDX_W-1:0] w_upd_idx;
  logic               w_any_invalid;
  logic [c_IDX_W-1:0] w_free_idx;
  logic [c_IDX_W-1:0] w_alloc_idx;
  cnt_t               w_cnt_cur;
  cnt_t               w_cnt_next;
  btb_entry_t         w_lk_entry;
  logic [31:0]        w_ras_top;
  logic               w_ras_empty;
  logic               w_ras_full;

  // Tag search for lookup and update ports; descending scan makes the lowest free index win.
  always_comb begin
    w_lk_hit      = 1'b0;
    w_lk_idx      = '0;
    w_upd_hit     = 1'b0;
    w_upd_idx     = '0;
    w_any_invalid = 1'b0;
    w_free_idx    = '0;
    for (int i = BTB_ENTRIES - 1; i >= 0; i--) begin
      if (r_btb[i].valid && (r_btb[i].pc == LOOKUP_ADR_SI)) begin
        w_lk_hit = 1'b1;
        w_lk_idx = c_IDX_W'(i);
      end
      if (r_btb[i].valid && (r_btb[i].pc == UPD_ADR_RD)) begin
        w_upd_hit = 1'b1;
        w_upd_idx = c_IDX_W'(i);
      end
      if (!r_btb[i].valid) begin
        w_any_invalid = 1'b1;
        w_free_idx    = c_IDX_W'(i);
      end
    end
  end

  assign w_alloc_idx = w_any_invalid ? w_free_idx : r_rr_ptr;
  assign w_cnt_cur   = r_btb[w_upd_idx].cnt;

  always_comb begin
    w_cnt_next = w_cnt_cur;
    if (UPD_TAKEN_RD) begin
      if (w_cnt_cur != c_CNT_MAX) begin
        w_cnt_next = w_cnt_cur + cnt_t'(1);
      end
    end else if (w_cnt_cur != '0) begin
      w_cnt_next = w_cnt_cur - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || FLUSH_ALL_SD) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_btb[i].valid <= 1'b0;
      end
      r_rr_ptr <= '0;
    end else if (UPD_VALID_RD) begin
      if (w_upd_hit) begin
        r_btb[w_upd_idx].cnt    <= w_cnt_next;
        r_btb[w_upd_idx].is_ret <= br_type_e'(UPD_IS_RET_RD);
        if (UPD_TAKEN_RD) begin
          r_btb[w_upd_idx].target <= UPD_TARGET_RD;
        end
      end else if (UPD_TAKEN_RD) begin
        r_btb[w_alloc_idx] <= '{valid:  1'b1,
                                is_ret: br_type_e'(UPD_IS_RET_RD),
                                pc:     UPD_ADR_RD,
                                target: UPD_TARGET_RD,
                                cnt:    c_CNT_INIT};
        // The pointer only moves when a live entry is evicted.
        if (!w_any_invalid) begin
          r_rr_ptr <= (r_rr_ptr == c_IDX_W'(BTB_ENTRIES - 1)) ? '0 : r_rr_ptr + c_IDX_W'(1);
        end
      end
    end
  end

  ret_addr_stack #(
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_flush    (FLUSH_ALL_SD),
    .i_push     (RAS_PUSH_RD),
    .i_push_adr (RAS_PUSH_ADR_RD),
    .i_pop      (RAS_POP_RD),
    .o_top_adr  (w_ras_top),
    .o_full     (w_ras_full),
    .o_empty    (w_ras_empty)
  );

  assign w_lk_entry = r_btb[w_lk_idx];

  always_comb begin
    BTB_HIT_SI    = 1'b0;
    PRED_TAKEN_SI = 1'b0;
    PRED_ADR_SI   = LOOKUP_ADR_SI + 32'd4;
    if (LOOKUP_VALID_SI && w_lk_hit) begin
      BTB_HIT_SI = 1'b1;
      if (w_lk_entry.is_ret == BR_RET) begin
        PRED_TAKEN_SI = ~w_ras_empty;
        PRED_ADR_SI   = w_ras_top;
      end else begin
        PRED_TAKEN_SI = w_lk_entry.cnt[CNT_WIDTH-1];
        PRED_ADR_SI   = w_lk_entry.target;
      end
    end
  end

  assign RAS_FULL_SI  = w_ras_full;
  assign RAS_EMPTY_SI = w_ras_empty;

endmodule

`default_nettype wire

// File: tb/tb_branch_pred.sv
// ============================================================================
// Module  : tb_branch_pred
// Brief   : Vector-table bench for branch_pred with an expectation queue.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_pred;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        LOOKUP_VALID_SI;
  logic [31:0] LOOKUP_ADR_SI;
  logic        PRED_TAKEN_SI;
  logic [31:0] PRED_ADR_SI;
  logic        BTB_HIT_SI;
  logic        UPD_VALID_RD;
  logic [31:0] UPD_ADR_RD;
  logic [31:0] UPD_TARGET_RD;
  logic        UPD_TAKEN_RD;
  logic        UPD_IS_RET_RD;
  logic        RAS_PUSH_RD;
  logic [31:0] RAS_PUSH_ADR_RD;
  logic        RAS_POP_RD;
  logic        FLUSH_ALL_SD;
  logic        RAS_FULL_SI;
  logic        RAS_EMPTY_SI;

  always #5 clk = ~clk;

  branch_pred #(
    .BTB_ENTRIES (4),
    .RAS_DEPTH   (8),
    .CNT_WIDTH   (2)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .LOOKUP_VALID_SI (LOOKUP_VALID_SI),
    .LOOKUP_ADR_SI   (LOOKUP_ADR_SI),
    .PRED_TAKEN_SI   (PRED_TAKEN_SI),
    .PRED_ADR_SI     (PRED_ADR_SI),
    .BTB_HIT_SI      (BTB_HIT_SI),
    .UPD_VALID_RD    (UPD_VALID_RD),
    .UPD_ADR_RD      (UPD_ADR_RD),
    .UPD_TARGET_RD   (UPD_TARGET_RD),
    .UPD_TAKEN_RD    (UPD_TAKEN_RD),
    .UPD_IS_RET_RD   (UPD_IS_RET_RD),
    .RAS_PUSH_RD     (RAS_PUSH_RD),
    .RAS_PUSH_ADR_RD (RAS_PUSH_ADR_RD),
    .RAS_POP_RD      (RAS_POP_RD),
    .FLUSH_ALL_SD    (FLUSH_ALL_SD),
    .RAS_FULL_SI     (RAS_FULL_SI),
    .RAS_EMPTY_SI    (RAS_EMPTY_SI)
  );

  // Expectations describe the outputs during the cycle, before that cycle's updates commit.
  typedef struct {
    bit          rst_n, flush, lk_valid;
    logic [31:0] lk_adr;
    bit          upd_valid, upd_taken, upd_ret;
    logic [31:0] upd_adr, upd_tgt;
    bit          push, pop;
    logic [31:0] push_adr;
    bit          chk_adr;
    bit          e_hit, e_taken, e_full, e_empty;
    logic [31:0] e_adr;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t look(input logic [31:0] adr, input bit hit, input bit taken,
                                input logic [31:0] eadr, input bit full, input bit empty);
    vec_t v;
    v = '{rst_n: 1'b1, flush: 1'b0, lk_valid: 1'b1, lk_adr: adr,
          upd_valid: 1'b0, upd_taken: 1'b0, upd_ret: 1'b0, upd_adr: 32'h0, upd_tgt: 32'h0,
          push: 1'b0, pop: 1'b0, push_adr: 32'h0, chk_adr: 1'b1,
          e_hit: hit, e_taken: taken, e_full: full, e_empty: empty, e_adr: eadr};
    return v;
  endfunction

  function automatic vec_t upd(input vec_t vi, input logic [31:0] adr, input logic [31:0] tgt,
                               input bit taken, input bit ret);
    vec_t v = vi;
    v.upd_valid = 1'b1; v.upd_adr = adr; v.upd_tgt = tgt; v.upd_taken = taken; v.upd_ret = ret;
    return v;
  endfunction

  function automatic vec_t psh(input vec_t vi, input logic [31:0] adr);
    vec_t v = vi;
    v.push = 1'b1; v.push_adr = adr;
    return v;
  endfunction

  function automatic vec_t pp(input vec_t vi);
    vec_t v = vi;
    v.pop = 1'b1;
    return v;
  endfunction

  function automatic vec_t fl(input vec_t vi);
    vec_t v = vi;
    v.flush = 1'b1;
    return v;
  endfunction

  function automatic vec_t nadr(input vec_t vi);
    vec_t v = vi;
    v.chk_adr = 1'b0;
    return v;
  endfunction

  function automatic vec_t nolk(input vec_t vi);
    vec_t v = vi;
    v.lk_valid = 1'b0;
    return v;
  endfunction

  function automatic vec_t rst(input vec_t vi);
    vec_t v = vi;
    v.rst_n = 1'b0;
    return v;
  endfunction

  task automatic cmp(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  initial begin
    vec_t e;

    // Counter walk on 0x100, including both saturation points and target retention.
    vecs.push_back(look(32'h100, 0, 0, 32'h104, 0, 1));
    vecs.push_back(upd(look(32'h100, 0, 0, 32'h104, 0, 1), 32'h100, 32'h200, 1, 0));
    vecs.push_back(upd(look(32'h100, 1, 1, 32'h200, 0, 1), 32'h100, 32'h0, 0, 0));
    vecs.push_back(upd(look(32'h100, 1, 0, 32'h200, 0, 1), 32'h100, 32'h0, 0, 0));
    vecs.push_back(upd(look(32'h100, 1, 0, 32'h200, 0, 1), 32'h100, 32'h0, 0, 0));
    vecs.push_back(upd(look(32'h100, 1, 0, 32'h200, 0, 1), 32'h100, 32'h280, 1, 0));
    vecs.push_back(upd(look(32'h100, 1, 0, 32'h280, 0, 1), 32'h100, 32'h280, 1, 0));
    vecs.push_back(upd(look(32'h100, 1, 1, 32'h280, 0, 1), 32'h100, 32'h280, 1, 0));
    vecs.push_back(upd(look(32'h100, 1, 1, 32'h280, 0, 1), 32'h100, 32'h280, 1, 0));
    vecs.push_back(upd(look(32'h100, 1, 1, 32'h280, 0, 1), 32'h100, 32'h0, 0, 0));
    vecs.push_back(look(32'h100, 1, 1, 32'h280, 0, 1));
    // Flush beats a same-cycle update and push.
    vecs.push_back(fl(psh(upd(look(32'h100, 1, 1, 32'h280, 0, 1), 32'h500, 32'h5000, 1, 0), 32'hAAA)));
    vecs.push_back(look(32'h100, 0, 0, 32'h104, 0, 1));
    vecs.push_back(look(32'h500, 0, 0, 32'h504, 0, 1));
    // Fill four entries, then evict in round-robin order.
    vecs.push_back(upd(look(32'h10, 0, 0, 32'h14, 0, 1), 32'h10, 32'h1010, 1, 0));
    vecs.push_back(upd(look(32'h10, 1, 1, 32'h1010, 0, 1), 32'h20, 32'h1020, 1, 0));
    vecs.push_back(upd(look(32'h20, 1, 1, 32'h1020, 0, 1), 32'h30, 32'h1030, 1, 0));
    vecs.push_back(upd(look(32'h30, 1, 1, 32'h1030, 0, 1), 32'h40, 32'h1040, 1, 0));
    vecs.push_back(upd(look(32'h50, 0, 0, 32'h54, 0, 1), 32'h50, 32'h1050, 1, 0));
    vecs.push_back(look(32'h10, 0, 0, 32'h14, 0, 1));
    vecs.push_back(upd(look(32'h50, 1, 1, 32'h1050, 0, 1), 32'h60, 32'h1060, 1, 0));
    vecs.push_back(look(32'h20, 0, 0, 32'h24, 0, 1));
    vecs.push_back(look(32'h30, 1, 1, 32'h1030, 0, 1));
    vecs.push_back(look(32'h60, 1, 1, 32'h1060, 0, 1));
    vecs.push_back(upd(look(32'h70, 0, 0, 32'h74, 0, 1), 32'h70, 32'h1070, 0, 0));
    vecs.push_back(look(32'h70, 0, 0, 32'h74, 0, 1));
    vecs.push_back(nolk(look(32'h30, 0, 0, 32'h34, 0, 1)));
    // Return entry at 0x300 replaces entry 2 (0x30) and follows the RAS top.
    vecs.push_back(psh(upd(look(32'h300, 0, 0, 32'h304, 0, 1), 32'h300, 32'h999, 1, 1), 32'h1234));
    vecs.push_back(look(32'h300, 1, 1, 32'h1234, 0, 0));
    vecs.push_back(pp(look(32'h300, 1, 1, 32'h1234, 0, 0)));
    vecs.push_back(nadr(look(32'h300, 1, 0, 32'h0, 0, 1)));
    vecs.push_back(look(32'h30, 0, 0, 32'h34, 0, 1));
    // Nine pushes into an eight-deep stack, then drain.
    for (int i = 0; i < 9; i++) begin
      e = psh(look(32'h300, 1, i != 0, 32'h1000 + i - 1, i == 8, i == 0), 32'h1000 + i);
      vecs.push_back(i == 0 ? nadr(e) : e);
    end
    vecs.push_back(look(32'h300, 1, 1, 32'h1008, 1, 0));
    for (int j = 0; j < 8; j++) begin
      vecs.push_back(pp(look(32'h300, 1, 1, 32'h1008 - j, j == 0, 0)));
    end
    vecs.push_back(nadr(pp(look(32'h300, 1, 0, 32'h0, 0, 1))));
    vecs.push_back(nadr(psh(pp(look(32'h300, 1, 0, 32'h0, 0, 1)), 32'hBEEF)));
    vecs.push_back(psh(pp(look(32'h300, 1, 1, 32'hBEEF, 0, 0)), 32'hC0DE));
    vecs.push_back(pp(look(32'h300, 1, 1, 32'hC0DE, 0, 0)));
    vecs.push_back(nadr(look(32'h300, 1, 0, 32'h0, 0, 1)));
    // Reset in the middle of traffic drops that cycle's update and push.
    vecs.push_back(rst(psh(upd(look(32'h50, 1, 1, 32'h1050, 0, 1), 32'h900, 32'h9000, 1, 0), 32'h7777)));
    vecs.push_back(look(32'h900, 0, 0, 32'h904, 0, 1));
    vecs.push_back(look(32'h50, 0, 0, 32'h54, 0, 1));

    reset_n = 1'b0; LOOKUP_VALID_SI = 1'b0; LOOKUP_ADR_SI = '0;
    UPD_VALID_RD = 1'b0; UPD_ADR_RD = '0; UPD_TARGET_RD = '0; UPD_TAKEN_RD = 1'b0; UPD_IS_RET_RD = 1'b0;
    RAS_PUSH_RD = 1'b0; RAS_PUSH_ADR_RD = '0; RAS_POP_RD = 1'b0; FLUSH_ALL_SD = 1'b0;
    repeat (2) @(posedge clk);

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      reset_n         = vecs[k].rst_n;
      FLUSH_ALL_SD    = vecs[k].flush;
      LOOKUP_VALID_SI = vecs[k].lk_valid;
      LOOKUP_ADR_SI   = vecs[k].lk_adr;
      UPD_VALID_RD    = vecs[k].upd_valid;
      UPD_ADR_RD      = vecs[k].upd_adr;
      UPD_TARGET_RD   = vecs[k].upd_tgt;
      UPD_TAKEN_RD    = vecs[k].upd_taken;
      UPD_IS_RET_RD   = vecs[k].upd_ret;
      RAS_PUSH_RD     = vecs[k].push;
      RAS_PUSH_ADR_RD = vecs[k].push_adr;
      RAS_POP_RD      = vecs[k].pop;
      sb.push_back(vecs[k]);
      #1;
      e = sb.pop_front();
      cmp(k, "hit",   {31'h0, BTB_HIT_SI},    {31'h0, e.e_hit});
      cmp(k, "taken", {31'h0, PRED_TAKEN_SI}, {31'h0, e.e_taken});
      cmp(k, "full",  {31'h0, RAS_FULL_SI},   {31'h0, e.e_full});
      cmp(k, "empty", {31'h0, RAS_EMPTY_SI},  {31'h0, e.e_empty});
      if (e.chk_adr) begin
        cmp(k, "pred_adr", PRED_ADR_SI, e.e_adr);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
